// File: rtl/w_writeback_grf.sv
// rtl/w_writeback_grf.sv - W-stage writeback, 32x32 GPR file, W->D bypass, commit trace, retire counter
//
// Purpose:
//   Selects the writeback value for the W-stage instruction and commits it to the
//   general register file. Serves two combinational D-stage read ports that bypass
//   the value being committed in the same cycle. Publishes a registered commit trace
//   and counts retired commits.
//
// Ports:
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   w_pc, w_write_reg, w_wb_sel   W-stage PC, destination GPR and writeback source select
//   w_alu_result, w_mem_data,
//   w_md_value, w_cp0_out         candidate writeback values
//   d_rs_addr/d_rt_addr           D-stage read addresses
//   d_rs_data/d_rt_data           D-stage read data (combinational, bypassed)
//   w_fwd_data, w_we              selected writeback value and commit strobe
//   trace_valid/pc/reg/data       registered trace of last cycle's commit
//   retire_cnt                    commits since reset
module w_writeback_grf #(
    parameter int CNT_W    = 32,
    parameter bit TRACE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      w_pc,
    input  logic [4:0]       w_write_reg,
    input  logic [2:0]       w_wb_sel,
    input  logic [31:0]      w_alu_result,
    input  logic [31:0]      w_mem_data,
    input  logic [31:0]      w_md_value,
    input  logic [31:0]      w_cp0_out,
    input  logic [4:0]       d_rs_addr,
    input  logic [4:0]       d_rt_addr,
    output logic [31:0]      d_rs_data,
    output logic [31:0]      d_rt_data,
    output logic [31:0]      w_fwd_data,
    output logic             w_we,
    output logic             trace_valid,
    output logic [31:0]      trace_pc,
    output logic [4:0]       trace_reg,
    output logic [31:0]      trace_data,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [2:0] SEL_ALU  = 3'd1;
    localparam logic [2:0] SEL_MEM  = 3'd2;
    localparam logic [2:0] SEL_LINK = 3'd3;
    localparam logic [2:0] SEL_MDU  = 3'd4;
    localparam logic [2:0] SEL_CP0  = 3'd5;

    logic [31:0]      wData;
    logic             selValid;
    logic [31:0]      grf [0:31];
    logic [CNT_W-1:0] retireCnt;

    always_comb begin
        wData = 32'd0;
        case (w_wb_sel)
            SEL_ALU:  wData = w_alu_result;
            SEL_MEM:  wData = w_mem_data;
            SEL_LINK: wData = w_pc + 32'd8;
            SEL_MDU:  wData = w_md_value;
            SEL_CP0:  wData = w_cp0_out;
            default:  wData = 32'd0;
        endcase
    end

    assign selValid   = (w_wb_sel >= SEL_ALU) && (w_wb_sel <= SEL_CP0);
    assign w_we       = (w_write_reg != 5'd0) && selValid;
    assign w_fwd_data = wData;

    // Entry 0 is cleared by reset and never written (w_we excludes reg 0); reads of
    // address 0 are forced to zero anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                grf[i] <= 32'd0;
            end
        end else if (w_we) begin
            grf[w_write_reg] <= wData;
        end
    end

    // Same-cycle bypass: a D-stage read of the register being committed sees the new value.
    always_comb begin
        d_rs_data = 32'd0;
        if (d_rs_addr == 5'd0) begin
            d_rs_data = 32'd0;
        end else if (w_we && (d_rs_addr == w_write_reg)) begin
            d_rs_data = wData;
        end else begin
            d_rs_data = grf[d_rs_addr];
        end
    end

    always_comb begin
        d_rt_data = 32'd0;
        if (d_rt_addr == 5'd0) begin
            d_rt_data = 32'd0;
        end else if (w_we && (d_rt_addr == w_write_reg)) begin
            d_rt_data = wData;
        end else begin
            d_rt_data = grf[d_rt_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retireCnt <= '0;
        end else if (w_we) begin
            retireCnt <= retireCnt + 1'b1;
        end
    end

    assign retire_cnt = retireCnt;

    generate
        if (TRACE_EN) begin : gTrace
            logic        traceValidQ;
            logic [31:0] tracePcQ;
            logic [4:0]  traceRegQ;
            logic [31:0] traceDataQ;

            // Payload holds its last committed value when no commit occurs.
            always_ff @(posedge clk) begin
                if (reset) begin
                    traceValidQ <= 1'b0;
                    tracePcQ    <= 32'd0;
                    traceRegQ   <= 5'd0;
                    traceDataQ  <= 32'd0;
                end else begin
                    traceValidQ <= w_we;
                    if (w_we) begin
                        tracePcQ   <= w_pc;
                        traceRegQ  <= w_write_reg;
                        traceDataQ <= wData;
                    end
                end
            end

            assign trace_valid = traceValidQ;
            assign trace_pc    = tracePcQ;
            assign trace_reg   = traceRegQ;
            assign trace_data  = traceDataQ;
        end else begin : gNoTrace
            assign trace_valid = 1'b0;
            assign trace_pc    = 32'd0;
            assign trace_reg   = 5'd0;
            assign trace_data  = 32'd0;
        end
    endgenerate

endmodule

// File: tb/tb_w_writeback_grf.sv
// tb/tb_w_writeback_grf.sv - self-checking bench for w_writeback_grf with a reference model
module tb_w_writeback_grf;

    logic        clk;
    logic        reset;
    logic [31:0] w_pc;
    logic [4:0]  w_write_reg;
    logic [2:0]  w_wb_sel;
    logic [31:0] w_alu_result;
    logic [31:0] w_mem_data;
    logic [31:0] w_md_value;
    logic [31:0] w_cp0_out;
    logic [4:0]  d_rs_addr;
    logic [4:0]  d_rt_addr;
    logic [31:0] d_rs_data;
    logic [31:0] d_rt_data;
    logic [31:0] w_fwd_data;
    logic        w_we;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [4:0]  trace_reg;
    logic [31:0] trace_data;
    logic [31:0] retire_cnt;

    w_writeback_grf #(.CNT_W(32), .TRACE_EN(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .w_pc         (w_pc),
        .w_write_reg  (w_write_reg),
        .w_wb_sel     (w_wb_sel),
        .w_alu_result (w_alu_result),
        .w_mem_data   (w_mem_data),
        .w_md_value   (w_md_value),
        .w_cp0_out    (w_cp0_out),
        .d_rs_addr    (d_rs_addr),
        .d_rt_addr    (d_rt_addr),
        .d_rs_data    (d_rs_data),
        .d_rt_data    (d_rt_data),
        .w_fwd_data   (w_fwd_data),
        .w_we         (w_we),
        .trace_valid  (trace_valid),
        .trace_pc     (trace_pc),
        .trace_reg    (trace_reg),
        .trace_data   (trace_data),
        .retire_cnt   (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [31:0] refRegs [32];
    logic        refTValid;
    logic [31:0] refTPc;
    logic [4:0]  refTReg;
    logic [31:0] refTData;
    logic [31:0] refCnt;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refWdata(input logic [2:0] sel, input logic [31:0] pc,
                                             input logic [31:0] alu, input logic [31:0] mem,
                                             input logic [31:0] md, input logic [31:0] cp0);
        logic [31:0] src [8];
        src[0] = 32'd0; src[1] = alu;  src[2] = mem;  src[3] = pc + 32'd8;
        src[4] = md;    src[5] = cp0;  src[6] = 32'd0; src[7] = 32'd0;
        return src[sel];
    endfunction

    function automatic logic [31:0] refRead(input logic [4:0] addr, input logic we,
                                            input logic [4:0] wr, input logic [31:0] wd);
        if (addr == 5'd0) return 32'd0;
        if (we && addr == wr) return wd;
        return refRegs[addr];
    endfunction

    // One clock: drive inputs, check combinational outputs, then check registered state.
    task automatic step(input logic rst, input logic [31:0] pc, input logic [4:0] wr,
                        input logic [2:0] sel, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] md, input logic [31:0] cp0,
                        input logic [4:0] ra, input logic [4:0] rb);
        logic [31:0] expWd;
        logic        expWe;
        @(negedge clk);
        reset = rst; w_pc = pc; w_write_reg = wr; w_wb_sel = sel;
        w_alu_result = alu; w_mem_data = mem; w_md_value = md; w_cp0_out = cp0;
        d_rs_addr = ra; d_rt_addr = rb;
        expWd = refWdata(sel, pc, alu, mem, md, cp0);
        expWe = (wr != 5'd0) && (sel >= 3'd1) && (sel <= 3'd5);
        #1;
        checkVal("fwd_data", w_fwd_data, expWd);
        checkVal("we", {31'd0, w_we}, {31'd0, expWe});
        checkVal("rs_data", d_rs_data, refRead(ra, expWe, wr, expWd));
        checkVal("rt_data", d_rt_data, refRead(rb, expWe, wr, expWd));
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;
            refTValid = 1'b0; refTPc = 32'd0; refTReg = 5'd0; refTData = 32'd0; refCnt = 32'd0;
        end else begin
            refTValid = expWe;
            if (expWe) begin
                refRegs[wr] = expWd;
                refTPc = pc; refTReg = wr; refTData = expWd;
                refCnt = refCnt + 32'd1;
            end
        end
        #1;
        checkVal("trace_valid", {31'd0, trace_valid}, {31'd0, refTValid});
        checkVal("trace_pc", trace_pc, refTPc);
        checkVal("trace_reg", {27'd0, trace_reg}, {27'd0, refTReg});
        checkVal("trace_data", trace_data, refTData);
        checkVal("retire_cnt", retire_cnt, refCnt);
    endtask

    initial begin
        reset = 1'b1; w_pc = 0; w_write_reg = 0; w_wb_sel = 0;
        w_alu_result = 0; w_mem_data = 0; w_md_value = 0; w_cp0_out = 0;
        d_rs_addr = 0; d_rt_addr = 0;
        for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;
        refTValid = 0; refTPc = 0; refTReg = 0; refTData = 0; refCnt = 0;

        // Reset then read every register on both ports
        step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
        end
        checkVal("dir_cnt0", retire_cnt, 32'd0);

        // ALU commit with same-cycle bypass
        step(1'b0, 32'h100, 5'd5, 3'd1, 32'hDEADBEEF, 0, 0, 0, 5'd5, 5'd5);
        checkVal("dir_trace_reg5", {27'd0, trace_reg}, 32'd5);
        checkVal("dir_trace_data", trace_data, 32'hDEADBEEF);
        checkVal("dir_cnt1", retire_cnt, 32'd1);

        // LINK, including PC wraparound
        step(1'b0, 32'h0000_3000, 5'd31, 3'd3, 0, 0, 0, 0, 5'd31, 5'd5);
        checkVal("dir_link", trace_data, 32'h0000_3008);
        step(1'b0, 32'hFFFF_FFFC, 5'd31, 3'd3, 0, 0, 0, 0, 5'd31, 5'd0);
        checkVal("dir_link_wrap", trace_data, 32'h0000_0004);

        // Write to reg 0 is ignored
        step(1'b0, 32'h200, 5'd0, 3'd2, 0, 32'h1234, 0, 0, 5'd0, 5'd31);
        checkVal("dir_r0_cnt", retire_cnt, 32'd3);

        // Flushed slot between two commits to reg 7
        step(1'b0, 32'h300, 5'd7, 3'd1, 32'd5, 0, 0, 0, 5'd7, 5'd0);
        step(1'b0, 32'h0, 5'd0, 3'd0, 0, 0, 0, 0, 5'd7, 5'd7);
        step(1'b0, 32'h308, 5'd7, 3'd4, 0, 0, 32'd9, 0, 5'd7, 5'd7);
        step(1'b0, 32'h0, 5'd0, 3'd0, 0, 0, 0, 0, 5'd7, 5'd5);
        checkVal("dir_r7_data", d_rs_data, 32'd9);
        checkVal("dir_r7_cnt", retire_cnt, 32'd5);

        // Commit presented during reset is dropped
        step(1'b1, 32'h400, 5'd3, 3'd5, 0, 0, 0, 32'hAA, 5'd3, 5'd3);
        step(1'b0, 32'h0, 5'd0, 3'd0, 0, 0, 0, 0, 5'd3, 5'd7);
        checkVal("dir_rst_r3", d_rs_data, 32'd0);
        checkVal("dir_rst_cnt", retire_cnt, 32'd0);

        // Randomized traffic, addresses biased toward a small set to force collisions
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic [4:0]  wr, ra, rb;
            r  = ($urandom_range(0, 49) == 0);
            wr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rb = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 7));
            step(r, $urandom, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                 $urandom, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
